pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Program-counter sequencer directly upstream of Instruction_Fetch in the uPOWER core. Owns the 64-bit PC and generates the next fetch address each cycle: sequential +4, stall hold, or redirect to a resolved I-form (b) or B-form (bc) branch target. Drives a fetch-valid qualifier and a link-register write request for LK=1 branches. Stops fetching once the PC leaves the instruction-memory window.

Parameters:
RESET_VECTOR, 64'h0000_0000_0004_0000, PC value loaded on reset; base of the instruction-memory window.
IMEM_DEPTH, 101, number of 32-bit words in instruction memory; window is [RESET_VECTOR, RESET_VECTOR+4*IMEM_DEPTH).

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
stall_i  input  1  hold PC; no new fetch this cycle.
redirect_i  input  1  taken branch resolved this cycle.
br_cond_i  input  1  0 = I-form (use li_i); 1 = B-form (use bd_i).
br_abs_i  input  1  AA bit: 1 = absolute target, 0 = PC-relative.
br_lk_i  input  1  LK bit: request link-register write.
li_i  input  24  I-form LI field.
bd_i  input  14  B-form BD field.
br_pc_i  input  64  address of the branch instruction being resolved.
pc_o  output  64  current fetch address to Instruction_Fetch.
fetch_valid_o  output  1  pc_o is a valid fetch this cycle.
link_we_o  output  1  one-cycle link-register write strobe.
link_pc_o  output  64  value to write into LR (br_pc_i + 4).
halted_o  output  1  sequencer is in HALT.

Behaviour:
- Reset (rst=1 at an edge, from any state, including mid-redirect): pc_o=RESET_VECTOR, state=BOOT, fetch_valid_o=0, link_we_o=0, link_pc_o=0, halted_o=0. All other inputs are ignored.
- States: BOOT, RUN, BUBBLE, HALT. fetch_valid_o = (state==RUN) && !stall_i (combinational on stall_i only).
- BOOT: next state is RUN unconditionally; PC holds.
- RUN, priority redirect_i > stall_i > increment:
  - redirect_i: pc_o <= target; next state BUBBLE. Redirect is honoured even when stall_i=1.
  - stall_i: PC and state hold.
  - Otherwise: pc_o <= pc_o + 4.
- BUBBLE: fixed one-cycle branch-resolution penalty. PC holds at the target with fetch_valid_o=0, then RUN. A redirect_i arriving in BUBBLE is taken: the new target overwrites the PC and the state stays in BUBBLE.
- Target computation, 64-bit with wrap-around modulo 2^64:
  - ext = sign-extend({li_i,2'b00}) from 26 bits, or sign-extend({bd_i,2'b00}) from 16 bits, selected by br_cond_i.
  - target = br_abs_i ? ext : br_pc_i + ext.
- Link write: a redirect with br_lk_i=1 in cycle N gives link_we_o=1 and link_pc_o=br_pc_i+4 in cycle N+1, for exactly one cycle. link_pc_o holds its last value otherwise.
- Window check: HALT is entered when the next PC falls outside the window, on either the increment or the redirect path.
  - In that case the PC does not update; halted_o=1 from the next cycle; fetch_valid_o=0.
  - Last legal word: PC = RESET_VECTOR + 4*(IMEM_DEPTH-1). Incrementing from it enters HALT.
  - HALT is left only by rst. redirect_i and stall_i are ignored in HALT, but a link write from the redirect that caused HALT still issues.
- Latency: redirect to valid fetch at the target is 2 cycles (BUBBLE, then RUN).

Optional Feature:
REDIRECT_COUNT_EN:
- When defined: adds port redirect_cnt_o (output, 32). It counts honoured redirects, is cleared by rst, saturates at 32'hFFFF_FFFF, and does not increment in HALT.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package upower_fetch_pkg holds:
  - the state enum (BOOT/RUN/BUBBLE/HALT);
  - the default RESET_VECTOR;
  - the instruction width (32);
  - the LI and BD field widths (24, 14).
- One combinational sub-module, branch_target_calc: inputs br_cond_i, br_abs_i, li_i, bd_i, br_pc_i; output the 64-bit target. It is reused by the decode-stage branch unit.

Test Plan:
- Reset then 3 free-running cycles:
  - BOOT: pc_o=0x40000, fetch_valid_o=0.
  - Then pc_o=0x40000, 0x40004, 0x40008 with fetch_valid_o=1.
- I-form relative: br_pc_i=0x40010, li_i=24'h000004, AA=0, LK=1 → next cycle pc_o=0x40020, fetch_valid_o=0, link_we_o=1, link_pc_o=0x40014; following cycle fetch_valid_o=1.
- B-form negative: br_pc_i=0x40020, bd_i=14'h3FFC → pc_o=0x40010.
- B-form absolute: bd_i=14'h0004, AA=1 → target 0x10, outside the window → halted_o=1, PC held, fetch_valid_o=0; a subsequent redirect_i is ignored.
- Stall held 4 cycles with simultaneous redirect_i in the second cycle → redirect taken; PC then holds at the target while stall_i stays high.
- Sequential run to pc_o=0x40190 (word 100), then one increment → HALT. Pulse rst mid-BUBBLE → BOOT with pc_o=0x40000; with REDIRECT_COUNT_EN, redirect_cnt_o returns to 0.

Source files
------------

// File: rtl/upower_fetch_pkg.sv
// Shared fetch-side types and constants for the uPOWER front end.
// Used by pc_sequencer and branch_target_calc.
package upower_fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2,
        ST_HALT   = 2'd3
    } seq_state_e;

    localparam logic [63:0] DEF_RESET_VECTOR = 64'h0000_0000_0004_0000;
    localparam int          INSTR_W          = 32;
    localparam int          INSTR_BYTES      = INSTR_W / 8;
    localparam int          LI_W             = 24;
    localparam int          BD_W             = 14;
    localparam int          CNT_W            = 32;

    // True when addr lies inside [base, base + INSTR_BYTES*depth).
    function automatic logic in_window(input logic [63:0] addr,
                                       input logic [63:0] base,
                                       input int unsigned depth);
        logic [63:0] lim;
        lim = base + (64'(depth) * 64'(INSTR_BYTES));
        return (addr >= base) && (addr < lim);
    endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Branch target for I-form (b) and B-form (bc): sign-extended word offset,
// either absolute or added to the branch PC (wraps modulo 2^64).
module branch_target_calc
    import upower_fetch_pkg::*;
(
    input  logic            br_cond_i,
    input  logic            br_abs_i,
    input  logic [LI_W-1:0] li_i,
    input  logic [BD_W-1:0] bd_i,
    input  logic [63:0]     br_pc_i,
    output logic [63:0]     target_o
);

    logic [63:0] ext;

    always_comb begin
        if (br_cond_i)
            ext = {{(64-BD_W-2){bd_i[BD_W-1]}}, bd_i, 2'b00};
        else
            ext = {{(64-LI_W-2){li_i[LI_W-1]}}, li_i, 2'b00};
        target_o = br_abs_i ? ext : (br_pc_i + ext);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer feeding Instruction_Fetch: +4 / stall / redirect,
// one-cycle bubble after redirects, HALT on leaving the imem window.
// Optional `REDIRECT_COUNT_EN adds a saturating honoured-redirect counter.
module pc_sequencer
    import upower_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter int unsigned IMEM_DEPTH   = 101
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic            br_cond_i,
    input  logic            br_abs_i,
    input  logic            br_lk_i,
    input  logic [LI_W-1:0] li_i,
    input  logic [BD_W-1:0] bd_i,
    input  logic [63:0]     br_pc_i,
`ifdef REDIRECT_COUNT_EN
    output logic [CNT_W-1:0] redirect_cnt_o,
`endif
    output logic [63:0]     pc_o,
    output logic            fetch_valid_o,
    output logic            link_we_o,
    output logic [63:0]     link_pc_o,
    output logic            halted_o
);

    seq_state_e  state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        link_we_q, link_we_d;
    logic [63:0] link_pc_q, link_pc_d;
    logic [63:0] target;
    logic [63:0] pc_inc;
    logic        take_redirect;

    branch_target_calc u_btc (
        .br_cond_i (br_cond_i),
        .br_abs_i  (br_abs_i),
        .li_i      (li_i),
        .bd_i      (bd_i),
        .br_pc_i   (br_pc_i),
        .target_o  (target)
    );

    // Redirects are only honoured once fetching is live; BOOT and HALT ignore them.
    assign take_redirect = redirect_i && ((state_q == ST_RUN) || (state_q == ST_BUBBLE));
    assign pc_inc        = pc_q + 64'(INSTR_BYTES);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        link_we_d = 1'b0;
        link_pc_d = link_pc_q;
        if (take_redirect) begin
            if (br_lk_i) begin
                link_we_d = 1'b1;
                link_pc_d = br_pc_i + 64'(INSTR_BYTES);
            end
            if (in_window(target, RESET_VECTOR, IMEM_DEPTH)) begin
                pc_d    = target;
                state_d = ST_BUBBLE;
            end else begin
                state_d = ST_HALT;
            end
        end else begin
            case (state_q)
                ST_BOOT:   state_d = ST_RUN;
                ST_RUN: begin
                    if (!stall_i) begin
                        if (in_window(pc_inc, RESET_VECTOR, IMEM_DEPTH))
                            pc_d = pc_inc;
                        else
                            state_d = ST_HALT;
                    end
                end
                ST_BUBBLE: state_d = ST_RUN;
                default:   state_d = ST_HALT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_VECTOR;
            link_we_q <= 1'b0;
            link_pc_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            link_we_q <= link_we_d;
            link_pc_q <= link_pc_d;
        end
    end

    assign pc_o          = pc_q;
    assign fetch_valid_o = (state_q == ST_RUN) && !stall_i;
    assign link_we_o     = link_we_q;
    assign link_pc_o     = link_pc_q;
    assign halted_o      = (state_q == ST_HALT);

`ifdef REDIRECT_COUNT_EN
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

    always_comb begin
        redirect_cnt_d = redirect_cnt_q;
        if (take_redirect && (redirect_cnt_q != {CNT_W{1'b1}}))
            redirect_cnt_d = redirect_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            redirect_cnt_q <= '0;
        else
            redirect_cnt_q <= redirect_cnt_d;
    end

    assign redirect_cnt_o = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed walk-through followed by
// randomized traffic compared against a behavioural model.
module tb_pc_sequencer;
    import upower_fetch_pkg::*;

    localparam logic [63:0] RV    = 64'h0000_0000_0004_0000;
    localparam int          DEPTH = 101;
    localparam int M_BOOT = 0, M_RUN = 1, M_BUB = 2, M_HALT = 3;

    logic        clk = 1'b0;
    logic        rst, stall_i, redirect_i, br_cond_i, br_abs_i, br_lk_i;
    logic [23:0] li_i;
    logic [13:0] bd_i;
    logic [63:0] br_pc_i;
    logic [63:0] pc_o, link_pc_o;
    logic        fetch_valid_o, link_we_o, halted_o;
`ifdef REDIRECT_COUNT_EN
    logic [31:0] redirect_cnt_o;
`endif

    int checks = 0;
    int failures = 0;
    bit armed = 1'b0;

    logic [63:0] m_pc, m_lpc;
    logic [31:0] m_cnt;
    int          m_st;
    bit          m_lwe;

    pc_sequencer #(.RESET_VECTOR(RV), .IMEM_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .br_cond_i     (br_cond_i),
        .br_abs_i      (br_abs_i),
        .br_lk_i       (br_lk_i),
        .li_i          (li_i),
        .bd_i          (bd_i),
        .br_pc_i       (br_pc_i),
`ifdef REDIRECT_COUNT_EN
        .redirect_cnt_o(redirect_cnt_o),
`endif
        .pc_o          (pc_o),
        .fetch_valid_o (fetch_valid_o),
        .link_we_o     (link_we_o),
        .link_pc_o     (link_pc_o),
        .halted_o      (halted_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Target from the ISA rule: signed word offset times four, wrapped to 64 bits.
    function automatic logic [63:0] ref_target(input logic cond, input logic abs_b,
                                               input logic [23:0] li, input logic [13:0] bd,
                                               input logic [63:0] brpc);
        longint off;
        if (cond) begin
            off = longint'({50'd0, bd});
            if (bd[13]) off = off - 16384;
        end else begin
            off = longint'({40'd0, li});
            if (li[23]) off = off - 16777216;
        end
        off = off * 4;
        return abs_b ? 64'(off) : brpc + 64'(off);
    endfunction

    function automatic bit ref_inwin(input logic [63:0] a);
        return (a >= RV) && (a < RV + 64'(4 * DEPTH));
    endfunction

    task automatic ref_step();
        bit hon;
        logic [63:0] t;
        if (rst) begin
            m_pc = RV; m_st = M_BOOT; m_lwe = 0; m_lpc = 64'd0; m_cnt = 32'd0;
        end else begin
            hon   = redirect_i && (m_st == M_RUN || m_st == M_BUB);
            m_lwe = hon && br_lk_i;
            if (m_lwe) m_lpc = br_pc_i + 64'd4;
            if (hon) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
                t = ref_target(br_cond_i, br_abs_i, li_i, bd_i, br_pc_i);
                if (ref_inwin(t)) begin m_pc = t; m_st = M_BUB; end
                else m_st = M_HALT;
            end else if (m_st == M_BOOT || m_st == M_BUB) begin
                m_st = M_RUN;
            end else if (m_st == M_RUN && !stall_i) begin
                if (ref_inwin(m_pc + 64'd4)) m_pc = m_pc + 64'd4;
                else m_st = M_HALT;
            end
        end
    endtask

    // Compare at the falling edge with this cycle's inputs, then advance the model.
    task automatic cycle();
        @(negedge clk);
        if (armed) begin
            chk("pc", pc_o, m_pc);
            chk("fetch_valid", 64'(fetch_valid_o), 64'(m_st == M_RUN && !stall_i));
            chk("link_we", 64'(link_we_o), 64'(m_lwe));
            chk("link_pc", link_pc_o, m_lpc);
            chk("halted", 64'(halted_o), 64'(m_st == M_HALT));
`ifdef REDIRECT_COUNT_EN
            chk("redirect_cnt", 64'(redirect_cnt_o), 64'(m_cnt));
`endif
        end
        @(posedge clk);
        ref_step();
        #1;
    endtask

    task automatic idle();
        rst = 0; stall_i = 0; redirect_i = 0; br_cond_i = 0; br_abs_i = 0; br_lk_i = 0;
        li_i = 24'd0; bd_i = 14'd0; br_pc_i = 64'd0;
    endtask

    task automatic redir(input logic cond, input logic abs_b, input logic lk,
                         input logic [23:0] li, input logic [13:0] bd, input logic [63:0] brpc);
        redirect_i = 1; br_cond_i = cond; br_abs_i = abs_b; br_lk_i = lk;
        li_i = li; bd_i = bd; br_pc_i = brpc;
    endtask

    task automatic do_reset();
        idle(); rst = 1; cycle(); rst = 0;
    endtask

    initial begin
        idle();
        do_reset();
        armed = 1'b1;

        // BOOT then free-running fetch
        #1 chk("boot_pc", pc_o, 64'h40000);
        chk("boot_fv", 64'(fetch_valid_o), 64'd0);
        chk("boot_halt", 64'(halted_o), 64'd0);
        cycle();
        #1 chk("run0_pc", pc_o, 64'h40000); chk("run0_fv", 64'(fetch_valid_o), 64'd1);
        cycle();
        #1 chk("run1_pc", pc_o, 64'h40004);
        cycle();
        #1 chk("run2_pc", pc_o, 64'h40008); chk("run2_fv", 64'(fetch_valid_o), 64'd1);

        // I-form relative with link
        redir(0, 0, 1, 24'h000004, 14'd0, 64'h40010);
        cycle(); idle();
        #1 chk("iform_pc", pc_o, 64'h40020);
        chk("iform_fv", 64'(fetch_valid_o), 64'd0);
        chk("iform_lwe", 64'(link_we_o), 64'd1);
        chk("iform_lpc", link_pc_o, 64'h40014);
        cycle();
        #1 chk("iform_fv2", 64'(fetch_valid_o), 64'd1);
        chk("iform_lwe2", 64'(link_we_o), 64'd0);

        // B-form negative offset
        redir(1, 0, 0, 24'd0, 14'h3FFC, 64'h40020);
        cycle(); idle();
        #1 chk("bneg_pc", pc_o, 64'h40010);
        cycle();

        // Stall with redirect in its second cycle
        stall_i = 1; cycle();
        redir(0, 0, 0, 24'h000008, 14'd0, 64'h40040); stall_i = 1;
        cycle(); idle(); stall_i = 1;
        #1 chk("stall_redir_pc", pc_o, 64'h40060);
        cycle();
        #1 chk("stall_hold_pc", pc_o, 64'h40060); chk("stall_fv", 64'(fetch_valid_o), 64'd0);
        cycle();
        #1 chk("stall_hold_pc2", pc_o, 64'h40060);
        idle();
        #1 chk("unstall_fv", 64'(fetch_valid_o), 64'd1);

        // B-form absolute out of window -> HALT; later redirect ignored
        redir(1, 1, 1, 24'd0, 14'h0004, 64'h40060);
        cycle();
        redir(0, 0, 0, 24'h000004, 14'd0, 64'h40000);
        #1 chk("halt_flag", 64'(halted_o), 64'd1);
        chk("halt_pc", pc_o, 64'h40060);
        chk("halt_fv", 64'(fetch_valid_o), 64'd0);
        chk("halt_lwe", 64'(link_we_o), 64'd1);
        chk("halt_lpc", link_pc_o, 64'h40064);
        cycle();
        #1 chk("halt_ignore_pc", pc_o, 64'h40060); chk("halt_still", 64'(halted_o), 64'd1);

        // Run to the last legal word, then one more increment
        do_reset();
        cycle();
        for (int i = 0; i < 100; i++) cycle();
        #1 chk("last_word_pc", pc_o, 64'h40190); chk("last_word_fv", 64'(fetch_valid_o), 64'd1);
        cycle();
        #1 chk("end_halt", 64'(halted_o), 64'd1); chk("end_pc", pc_o, 64'h40190);
        chk("end_fv", 64'(fetch_valid_o), 64'd0);

        // Reset in the middle of a bubble
        do_reset();
        cycle();
        redir(0, 0, 0, 24'h000002, 14'd0, 64'h40000);
        cycle(); idle();
        #1 chk("bub_pc", pc_o, 64'h40008);
        rst = 1; cycle(); rst = 0;
        #1 chk("rst_bub_pc", pc_o, 64'h40000);
        chk("rst_bub_fv", 64'(fetch_valid_o), 64'd0);
        chk("rst_bub_lpc", link_pc_o, 64'd0);
`ifdef REDIRECT_COUNT_EN
        chk("rst_bub_cnt", 64'(redirect_cnt_o), 64'd0);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            idle();
            rst     = ($urandom_range(0, 199) == 0) || (m_st == M_HALT && $urandom_range(0, 7) == 0);
            stall_i = ($urandom_range(0, 3) == 0);
            br_lk_i = $urandom_range(0, 1);
            br_cond_i = $urandom_range(0, 1);
            if ($urandom_range(0, 4) == 0) begin
                redirect_i = 1;
                r = $urandom_range(0, 9);
                br_pc_i = RV + 64'(4 * $urandom_range(0, DEPTH - 1));
                li_i = 24'(int'($urandom_range(0, 240)) - 120);
                bd_i = 14'(int'($urandom_range(0, 240)) - 120);
                if (r == 8) begin
                    br_abs_i = 1;
                    li_i = 24'(32'h10000 + $urandom_range(0, DEPTH + 4));
                end else if (r == 9) begin
                    br_pc_i = {$urandom, $urandom};
                end
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
